// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail lamp sequencer.
// Build option: TAIL_LIGHT_BRAKE_EN (see tail_light_seq).
package tail_light_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_LEFT,
        MODE_RIGHT,
        MODE_HAZ
    } mode_t;

    // Widest lamp bank the thermometer helper can describe.
    localparam int THERM_MAX = 32;

    // Thermometer code: bit i set when step > i (lamps fill from the inside out).
    function automatic logic [THERM_MAX-1:0] therm(input int unsigned step);
        logic [THERM_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            v[i] = (step > i);
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step-rate divider: one-cycle tick every TICK_DIV clocks.
// TICK_DIV == 1 gives a tick on every clock (counter stays at zero).
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; restarts from zero on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/tail_light_seq.sv
// Turn/hazard lamp sequencer: grows a thermometer pattern across N_LAMPS
// lamps per side, one step per prescaled tick, then one dark step.
// Build option: TAIL_LIGHT_BRAKE_EN adds the brake input, which forces the
// non-sequencing side(s) fully on without touching the sequence state.
//
// state      | meaning
// MODE_IDLE  | lamps dark (step 0), requests sampled on each tick
// MODE_LEFT  | left side running steps 1..N_LAMPS
// MODE_RIGHT | right side running steps 1..N_LAMPS
// MODE_HAZ   | both sides running steps 1..N_LAMPS
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
`ifdef TAIL_LIGHT_BRAKE_EN
    input  logic               brake,
`endif
    output logic [N_LAMPS-1:0] l_lamps,
    output logic [N_LAMPS-1:0] r_lamps,
    output logic               busy
);

    localparam int SW = $clog2(N_LAMPS + 1);
    localparam logic [SW-1:0] STEP_FIRST = SW'(1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(N_LAMPS);

    if (N_LAMPS < 1 || TICK_DIV < 1 || N_LAMPS > THERM_MAX) begin : g_bad_param
        $error("tail_light_seq: need 1 <= N_LAMPS <= %0d and TICK_DIV >= 1", THERM_MAX);
    end

    logic               tick;
    mode_t              mode, mode_n;
    logic [SW-1:0]      step, step_n;
    logic [N_LAMPS-1:0] th;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Mode/step register; reset abandons any running sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= MODE_IDLE;
            step <= '0;
        end else begin
            mode <= mode_n;
            step <= step_n;
        end
    end

    // Next state: requests only matter in IDLE; sequences always run to the end.
    always_comb begin
        mode_n = mode;
        step_n = step;
        if (tick) begin
            case (mode)
                MODE_IDLE: begin
                    if (hazard || (left && right)) begin
                        mode_n = MODE_HAZ;
                        step_n = STEP_FIRST;
                    end else if (left) begin
                        mode_n = MODE_LEFT;
                        step_n = STEP_FIRST;
                    end else if (right) begin
                        mode_n = MODE_RIGHT;
                        step_n = STEP_FIRST;
                    end
                end
                default: begin
                    if (step == STEP_LAST) begin
                        mode_n = MODE_IDLE;
                        step_n = '0;
                    end else begin
                        step_n = step + SW'(1);
                    end
                end
            endcase
        end
    end

    assign th   = N_LAMPS'(therm(32'(step)));
    assign busy = (mode != MODE_IDLE);

    // Lamp decode from registered mode/step, with optional brake overlay.
    always_comb begin
        l_lamps = '0;
        r_lamps = '0;
        case (mode)
            MODE_LEFT:  l_lamps = th;
            MODE_RIGHT: r_lamps = th;
            MODE_HAZ: begin
                l_lamps = th;
                r_lamps = th;
            end
            default: ;
        endcase
`ifdef TAIL_LIGHT_BRAKE_EN
        if (brake) begin
            case (mode)
                MODE_IDLE: begin
                    l_lamps = '1;
                    r_lamps = '1;
                end
                MODE_LEFT:  r_lamps = '1;
                MODE_RIGHT: l_lamps = '1;
                default: ;
            endcase
        end
`endif
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: table of per-cycle vectors, a hand-written
// TICK_DIV=1 run, then random stimulus against a frame-queue reference model.
// Two instances share stimulus: TICK_DIV=4 and TICK_DIV=1, both N_LAMPS=3.
module tb_tail_light_seq;

    logic clk;
    logic reset, left, right, hazard;
`ifdef TAIL_LIGHT_BRAKE_EN
    logic brake;
`endif
    logic [2:0] l4, r4, l1, r1;
    logic       b4, b1;

    int total = 0;
    int bad   = 0;

    tail_light_seq #(.N_LAMPS(3), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(brake),
`endif
        .l_lamps(l4), .r_lamps(r4), .busy(b4)
    );

    tail_light_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(brake),
`endif
        .l_lamps(l1), .r_lamps(r1), .busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each instance keeps a queue of pending frames {kind, lit count}.
    // kind: 0 dark, 1 left, 2 right, 3 hazard. When the queue is empty on a
    // tick the requests are sampled and a whole sequence (N lit frames plus
    // one dark frame) is queued; every tick shows the next queued frame.
    localparam int N = 3;
    int cyc [2];
    int qk  [2][0:7];
    int qc  [2][0:7];
    int nq  [2];
    int ck  [2];
    int cc  [2];

    initial begin
        for (int id = 0; id < 2; id++) begin
            cyc[id] = 0; nq[id] = 0; ck[id] = 0; cc[id] = 0;
        end
    end

    always @(posedge clk) begin
        for (int id = 0; id < 2; id++) begin
            int td, k;
            td = (id == 0) ? 4 : 1;
            if (reset) begin
                cyc[id] = 0; nq[id] = 0; ck[id] = 0; cc[id] = 0;
            end else begin
                if ((cyc[id] % td) == td - 1) begin
                    if (nq[id] == 0) begin
                        k = hazard ? 3 : (left && right) ? 3 : left ? 1 : right ? 2 : 0;
                        if (k != 0) begin
                            for (int s = 1; s <= N; s++) begin
                                qk[id][nq[id]] = k; qc[id][nq[id]] = s; nq[id]++;
                            end
                            qk[id][nq[id]] = 0; qc[id][nq[id]] = 0; nq[id]++;
                        end
                    end
                    if (nq[id] > 0) begin
                        ck[id] = qk[id][0]; cc[id] = qc[id][0];
                        for (int j = 0; j < 7; j++) begin
                            qk[id][j] = qk[id][j+1]; qc[id][j] = qc[id][j+1];
                        end
                        nq[id]--;
                    end else begin
                        ck[id] = 0; cc[id] = 0;
                    end
                end
                cyc[id]++;
            end
        end
    end

    function automatic logic [2:0] therm3(int c);
        return 3'((1 << c) - 1);
    endfunction

    function automatic logic [2:0] m_l(int id);
        logic [2:0] v;
        v = (ck[id] == 1 || ck[id] == 3) ? therm3(cc[id]) : 3'b000;
`ifdef TAIL_LIGHT_BRAKE_EN
        if (brake && (ck[id] == 0 || ck[id] == 2)) v = 3'b111;
`endif
        return v;
    endfunction

    function automatic logic [2:0] m_r(int id);
        logic [2:0] v;
        v = (ck[id] == 2 || ck[id] == 3) ? therm3(cc[id]) : 3'b000;
`ifdef TAIL_LIGHT_BRAKE_EN
        if (brake && (ck[id] == 0 || ck[id] == 1)) v = 3'b111;
`endif
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0b, want %0b", nm, idx, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, lt, rt, hz, bk;
        logic [2:0] el, er;
        logic       eb;
    } vec_t;

    vec_t tbl [0:255];
    int   ntbl = 0;

    task automatic addn(input int n, input logic rs, input logic lt, input logic rt, input logic hz,
                        input logic bk, input logic [2:0] el, input logic [2:0] er, input logic eb);
        for (int i = 0; i < n; i++) begin
            tbl[ntbl] = '{rst: rs, lt: lt, rt: rt, hz: hz, bk: bk, el: el, er: er, eb: eb};
            ntbl++;
        end
    endtask

    task automatic drive(input logic rs, input logic lt, input logic rt, input logic hz, input logic bk);
        reset = rs; left = lt; right = rt; hazard = hz;
`ifdef TAIL_LIGHT_BRAKE_EN
        brake = bk;
`endif
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // idle after reset: dark for 20 cycles
        addn(2,  1,0,0,0,0, 3'b000,3'b000,0);
        addn(20, 0,0,0,0,0, 3'b000,3'b000,0);
        // left request held across the first tick
        addn(2,  1,0,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,1,0,0,0, 3'b000,3'b000,0);
        addn(1,  0,1,0,0,0, 3'b001,3'b000,1);
        addn(3,  0,0,0,0,0, 3'b001,3'b000,1);
        addn(4,  0,0,0,0,0, 3'b011,3'b000,1);
        addn(4,  0,0,0,0,0, 3'b111,3'b000,1);
        addn(3,  0,0,0,0,0, 3'b000,3'b000,0);
        // left+right gives hazard; then hazard+left gives hazard
        addn(2,  1,0,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,1,1,0,0, 3'b000,3'b000,0);
        addn(1,  0,1,1,0,0, 3'b001,3'b001,1);
        addn(3,  0,0,0,0,0, 3'b001,3'b001,1);
        addn(4,  0,0,0,0,0, 3'b011,3'b011,1);
        addn(4,  0,0,0,0,0, 3'b111,3'b111,1);
        addn(1,  0,0,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,1,0,1,0, 3'b000,3'b000,0);
        addn(1,  0,1,0,1,0, 3'b001,3'b001,1);
        addn(3,  0,0,0,0,0, 3'b001,3'b001,1);
        // reset during step 2 of left; prescaler restarts from zero
        addn(2,  1,0,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,1,0,0,0, 3'b000,3'b000,0);
        addn(1,  0,1,0,0,0, 3'b001,3'b000,1);
        addn(3,  0,0,0,0,0, 3'b001,3'b000,1);
        addn(1,  0,0,0,0,0, 3'b011,3'b000,1);
        addn(1,  1,1,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,1,0,0,0, 3'b000,3'b000,0);
        addn(1,  0,1,0,0,0, 3'b001,3'b000,1);
`ifdef TAIL_LIGHT_BRAKE_EN
        // brake overlays the idle/non-sequencing side, never hazard
        addn(2,  1,0,0,0,1, 3'b111,3'b111,0);
        addn(3,  0,1,0,0,1, 3'b111,3'b111,0);
        addn(1,  0,1,0,0,1, 3'b001,3'b111,1);
        addn(3,  0,0,0,0,1, 3'b001,3'b111,1);
        addn(4,  0,0,0,0,0, 3'b011,3'b000,1);
        addn(4,  0,0,0,0,0, 3'b111,3'b000,1);
        addn(1,  0,0,0,0,0, 3'b000,3'b000,0);
        addn(3,  0,0,0,1,1, 3'b111,3'b111,0);
        addn(1,  0,0,0,1,1, 3'b001,3'b001,1);
        addn(1,  0,0,0,0,1, 3'b001,3'b001,1);
`endif

        for (int i = 0; i < ntbl; i++) begin
            drive(tbl[i].rst, tbl[i].lt, tbl[i].rt, tbl[i].hz, tbl[i].bk);
            @(posedge clk); #1;
            chk("tbl_l_lamps", i, 32'(l4), 32'(tbl[i].el));
            chk("tbl_r_lamps", i, 32'(r4), 32'(tbl[i].er));
            chk("tbl_busy",    i, 32'(b4), 32'(tbl[i].eb));
        end

        // TICK_DIV=1, right held: period-4 pattern; a brief left is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            logic [2:0] er;
            drive(1'b0, (k == 1 || k == 2), 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
            case (k % 4)
                0: er = 3'b001;
                1: er = 3'b011;
                2: er = 3'b111;
                default: er = 3'b000;
            endcase
            chk("div1_r_lamps", k, 32'(r1), 32'(er));
            chk("div1_l_lamps", k, 32'(l1), 32'(3'b000));
            chk("div1_busy",    k, 32'(b1), 32'((k % 4) != 3));
        end

        // random stimulus against the reference model, both instances
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(299) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(2) == 0));
            @(posedge clk); #1;
            chk("rnd4_l_lamps", n, 32'(l4), 32'(m_l(0)));
            chk("rnd4_r_lamps", n, 32'(r4), 32'(m_r(0)));
            chk("rnd4_busy",    n, 32'(b4), 32'(ck[0] != 0));
            chk("rnd1_l_lamps", n, 32'(l1), 32'(m_l(1)));
            chk("rnd1_r_lamps", n, 32'(r1), 32'(m_r(1)));
            chk("rnd1_busy",    n, 32'(b1), 32'(ck[1] != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
